// File: rtl/output_deskew_buffer.sv
// Realigns the skewed per-column result stream from the systolic array into
// row vectors and buffers them in a FIFO. Optional macro OUTPUT_DESKEW_ROWCNT_EN adds row_count.
module output_deskew_buffer #(
  parameter int SA_SIZE     = 8,
  parameter int RESULT_SIZE = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [RESULT_SIZE-1:0]        in_data [SA_SIZE],
  input  logic [SA_SIZE-1:0]            in_valid,
  output logic [RESULT_SIZE-1:0]        out_data [SA_SIZE],
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow_err,
  output logic                          skew_err,
  input  logic                          clear_err
`ifdef OUTPUT_DESKEW_ROWCNT_EN
  ,
  output logic [31:0]                   row_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [RESULT_SIZE-1:0] col_data_s [SA_SIZE];
  logic [SA_SIZE-1:0]     col_valid_s;

`ifdef OUTPUT_DESKEW_ROWCNT_EN
`ifdef FORMAL
  logic [$clog2(SA_SIZE+1):0] warm_q;

  // Counts consecutive out-of-reset edges so $past only looks at loaded stages.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      warm_q <= '0;
    end else if (warm_q <= ($clog2(SA_SIZE+1)+1)'(SA_SIZE)) begin
      warm_q <= warm_q + ($clog2(SA_SIZE+1)+1)'(1);
    end else begin
      warm_q <= warm_q;
    end
  end
`endif
`endif

  // Column c gets SA_SIZE-c stages so every column lands on the same edge.
  for (genvar c = 0; c < SA_SIZE; c++) begin : g_col
    localparam int DEPTH = SA_SIZE - c;
    logic [RESULT_SIZE-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]       valid_q;

    // Free-running shift chain; never stalls.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        for (int k = 0; k < DEPTH; k++) begin
          data_q[k] <= '0;
        end
        valid_q <= '0;
      end else begin
        data_q[0]  <= in_data[c];
        valid_q[0] <= in_valid[c];
        for (int k = 1; k < DEPTH; k++) begin
          data_q[k]  <= data_q[k-1];
          valid_q[k] <= valid_q[k-1];
        end
      end
    end

    assign col_data_s[c]  = data_q[DEPTH-1];
    assign col_valid_s[c] = valid_q[DEPTH-1];

`ifdef OUTPUT_DESKEW_ROWCNT_EN
`ifdef FORMAL
    a_stage_delay: assert property (@(posedge clk)
      (resetn && (warm_q >= ($clog2(SA_SIZE+1)+1)'(DEPTH))) |->
      (data_q[DEPTH-1] == $past(in_data[c], DEPTH)));
`endif
`endif
  end

  logic [RESULT_SIZE-1:0] mem_q [FIFO_DEPTH][SA_SIZE];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d, skew_q, skew_d;
  logic                   row_valid_s, skew_evt_s, ovf_evt_s;
  logic                   empty_s, full_s, pop_s, push_s;

  // Row qualification, FIFO control and sticky-error next state.
  always_comb begin
    row_valid_s = &col_valid_s;
    skew_evt_s  = (|col_valid_s) && !row_valid_s;
    empty_s     = (count_q == '0);
    full_s      = (count_q == CNT_W'(FIFO_DEPTH));
    pop_s       = !empty_s && out_ready;
    push_s      = row_valid_s && (!full_s || pop_s);
    ovf_evt_s   = row_valid_s && full_s && !pop_s;
    wr_ptr_d    = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // An error event in the same cycle as clear_err keeps the flag set.
    overflow_d = ovf_evt_s || (overflow_q && !clear_err);
    skew_d     = skew_evt_s || (skew_q && !clear_err);
  end

  // FIFO pointers, occupancy and sticky flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      skew_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      skew_q     <= skew_d;
    end
  end

  // Row storage.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int r = 0; r < FIFO_DEPTH; r++) begin
        for (int c = 0; c < SA_SIZE; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else if (push_s) begin
      for (int c = 0; c < SA_SIZE; c++) begin
        mem_q[wr_ptr_q][c] <= col_data_s[c];
      end
    end else begin
      mem_q <= mem_q;
    end
  end

  // Head row straight from storage; zero while empty.
  always_comb begin
    for (int c = 0; c < SA_SIZE; c++) begin
      out_data[c] = empty_s ? '0 : mem_q[rd_ptr_q][c];
    end
  end

  assign out_valid    = !empty_s;
  assign fifo_count   = count_q;
  assign overflow_err = overflow_q;
  assign skew_err     = skew_q;

`ifdef OUTPUT_DESKEW_ROWCNT_EN
  logic [31:0] row_cnt_q, row_cnt_d;

  always_comb begin
    row_cnt_d = pop_s ? row_cnt_q + 32'd1 : row_cnt_q;
  end

  // Accepted-row counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      row_cnt_q <= 32'd0;
    end else begin
      row_cnt_q <= row_cnt_d;
    end
  end

  assign row_count = row_cnt_q;
`endif

endmodule

// File: tb/tb_output_deskew_buffer.sv
// Self-checking bench for output_deskew_buffer (SA_SIZE=4, FIFO_DEPTH=4): directed
// steps then random traffic, compared against a queue-based row model.
module tb_output_deskew_buffer;
  localparam int SA  = 4;
  localparam int W   = 32;
  localparam int D   = 4;
  localparam int TOT = SA * W;

  logic          clk;
  logic          resetn;
  logic [W-1:0]  in_data [SA];
  logic [SA-1:0] in_valid;
  logic [W-1:0]  out_data [SA];
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    fifo_count;
  logic          overflow_err;
  logic          skew_err;
  logic          clear_err;
`ifdef OUTPUT_DESKEW_ROWCNT_EN
  logic [31:0]   row_count;
  logic [31:0]   m_rows;
`endif

  output_deskew_buffer #(.SA_SIZE(SA), .RESULT_SIZE(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .overflow_err(overflow_err), .skew_err(skew_err),
    .clear_err(clear_err)
`ifdef OUTPUT_DESKEW_ROWCNT_EN
    , .row_count(row_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [SA-1:0]  v;
    logic [TOT-1:0] d;
  } samp_t;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [SA-1:0]  sv [64];
  logic [TOT-1:0] sd [64];
  samp_t          hist [$];
  logic [TOT-1:0] mq [$];
  logic           m_ovf, m_skew;

  task automatic chk(input string tag, input logic [TOT-1:0] obs, input logic [TOT-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TOT-1:0] packed_out();
    logic [TOT-1:0] p;
    for (int c = 0; c < SA; c++) p[c*W +: W] = out_data[c];
    return p;
  endfunction

  // Schedule a row: column c presented `off+c` cycles from now (one later for column `late`).
  task automatic add_row(input int off, input logic [TOT-1:0] row, input int late);
    for (int c = 0; c < SA; c++) begin
      int s;
      s = (cyc + off + c + ((c == late) ? 1 : 0)) % 64;
      sv[s][c] = 1'b1;
      sd[s][c*W +: W] = row[c*W +: W];
    end
  endtask

  function automatic bit slots_free(input int late);
    for (int c = 0; c < SA; c++) begin
      if (sv[(cyc + c + ((c == late) ? 1 : 0)) % 64][c]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Row-level reference: column c of the write candidate was presented SA-c edges ago.
  task automatic model_edge();
    bit             pop, full_row, ovf_evt, skew_evt;
    logic [SA-1:0]  cv;
    logic [TOT-1:0] cd, cur;
    samp_t          e;
    pop = (mq.size() != 0) && out_ready;
    for (int c = 0; c < SA; c++) begin
      e = hist[hist.size() - (SA - c)];
      cv[c] = e.v[c];
      cd[c*W +: W] = e.d[c*W +: W];
    end
    if (!resetn) begin
      mq.delete();
      hist.delete();
      m_ovf = 1'b0;
      m_skew = 1'b0;
`ifdef OUTPUT_DESKEW_ROWCNT_EN
      m_rows = 32'd0;
`endif
      for (int k = 0; k < SA; k++) hist.push_back('0);
    end else begin
      full_row = (cv == {SA{1'b1}});
      ovf_evt  = full_row && (mq.size() == D) && !pop;
      skew_evt = (cv != '0) && !full_row;
      if (pop) begin
        void'(mq.pop_front());
`ifdef OUTPUT_DESKEW_ROWCNT_EN
        m_rows = m_rows + 32'd1;
`endif
      end
      if (full_row && !ovf_evt) mq.push_back(cd);
      m_ovf  = (m_ovf && !clear_err) || ovf_evt;
      m_skew = (m_skew && !clear_err) || skew_evt;
      for (int c = 0; c < SA; c++) cur[c*W +: W] = in_data[c];
      hist.push_back('{v: in_valid, d: cur});
      void'(hist.pop_front());
    end
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, mq.size() != 0);
    chk("fifo_count", fifo_count, mq.size());
    chk("out_data", packed_out(), (mq.size() != 0) ? mq[0] : '0);
    chk("overflow_err", overflow_err, m_ovf);
    chk("skew_err", skew_err, m_skew);
`ifdef OUTPUT_DESKEW_ROWCNT_EN
    chk("row_count", row_count, m_rows);
`endif
  endtask

  // One clock: drive scheduled columns, advance model at the edge, check after it.
  task automatic step();
    int s;
    s = cyc % 64;
    in_valid = sv[s];
    for (int c = 0; c < SA; c++) in_data[c] = sv[s][c] ? sd[s][c*W +: W] : W'($urandom());
    sv[s] = '0;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TOT-1:0] rows [5];
    int lat, highs;
    for (int i = 0; i < 64; i++) begin sv[i] = '0; sd[i] = '0; end
    for (int k = 0; k < SA; k++) hist.push_back('0);
    m_ovf = 1'b0; m_skew = 1'b0;
`ifdef OUTPUT_DESKEW_ROWCNT_EN
    m_rows = 32'd0;
`endif
    resetn = 1'b0; out_ready = 1'b0; clear_err = 1'b0; in_valid = '0;
    for (int c = 0; c < SA; c++) in_data[c] = '0;
    @(negedge clk);
    step(); step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_errs", {overflow_err, skew_err}, 2'b00);
    resetn = 1'b1;
    step();

    // Single row, latency and one-cycle out_valid.
    out_ready = 1'b1;
    add_row(0, {32'h13, 32'h12, 32'h11, 32'h10}, -1);
    lat = 0; highs = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (out_valid) begin
        highs++;
        if (lat == 0) begin
          lat = k;
          chk("t1_data", packed_out(), {32'h13, 32'h12, 32'h11, 32'h10});
        end
      end
    end
    chk("t1_latency", lat, SA + 1);
    chk("t1_one_cycle", highs, 1);

    // Back-to-back rows with stall then drain.
    out_ready = 1'b0;
    add_row(0, {32'd4, 32'd3, 32'd2, 32'd1}, -1);
    add_row(1, {32'd8, 32'd7, 32'd6, 32'd5}, -1);
    repeat (8) step();
    chk("t2_count", fifo_count, 3'd2);
    repeat (3) step();
    chk("t2_stall_hold", packed_out(), {32'd4, 32'd3, 32'd2, 32'd1});
    out_ready = 1'b1;
    step();
    chk("t2_second", packed_out(), {32'd8, 32'd7, 32'd6, 32'd5});
    repeat (2) step();

    // Overflow: five rows into a four-deep FIFO.
    out_ready = 1'b0;
    for (int r = 0; r < 5; r++) begin
      rows[r] = {W'($urandom()), W'($urandom()), W'($urandom()), W'($urandom())};
      add_row(r, rows[r], -1);
    end
    repeat (12) step();
    chk("t3_count", fifo_count, 3'd4);
    chk("t3_overflow", overflow_err, 1'b1);
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      chk("t3_order", packed_out(), rows[r]);
      step();
    end
    chk("t3_empty", out_valid, 1'b0);
    clear_err = 1'b1; step(); clear_err = 1'b0;
    chk("t3_cleared", overflow_err, 1'b0);

    // Full FIFO with simultaneous pop and push.
    out_ready = 1'b0;
    for (int r = 0; r < 4; r++) add_row(r, {W'($urandom()), W'($urandom()), W'($urandom()), W'($urandom())}, -1);
    repeat (10) step();
    add_row(0, {32'hA4, 32'hA3, 32'hA2, 32'hA1}, -1);
    repeat (4) step();
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("t4_count", fifo_count, 3'd4);
    chk("t4_no_ovf", overflow_err, 1'b0);
    out_ready = 1'b1; repeat (6) step();

    // Late column 2: skew error wins over a same-cycle clear, then clears.
    add_row(0, {32'hB4, 32'hB3, 32'hB2, 32'hB1}, 2);
    repeat (4) step();
    clear_err = 1'b1; step(); clear_err = 1'b0;
    chk("t5_skew_wins", skew_err, 1'b1);
    repeat (4) step();
    chk("t5_no_row", fifo_count, 3'd0);
    clear_err = 1'b1; step(); clear_err = 1'b0;
    chk("t5_cleared", skew_err, 1'b0);

    // Reset with two rows buffered and one mid-skew.
    out_ready = 1'b0;
    add_row(0, {32'hC4, 32'hC3, 32'hC2, 32'hC1}, -1);
    add_row(1, {32'hC8, 32'hC7, 32'hC6, 32'hC5}, -1);
    repeat (8) step();
    add_row(0, {32'hD4, 32'hD3, 32'hD2, 32'hD1}, -1);
    repeat (2) step();
    resetn = 1'b0; step(); resetn = 1'b1;
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_count", fifo_count, 3'd0);
    highs = 0;
    repeat (10) begin step(); if (out_valid) highs++; end
    chk("t6_nothing", highs, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      int late;
      out_ready = 1'($urandom_range(0, 1));
      clear_err = ($urandom_range(0, 19) == 0);
      resetn = ($urandom_range(0, 149) != 0);
      late = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, SA - 1)) : -1;
      if ($urandom_range(0, 2) != 0 && slots_free(late))
        add_row(0, {W'($urandom()), W'($urandom()), W'($urandom()), W'($urandom())}, late);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
